// File: rtl/alu_share_arbiter_pkg.sv
// alu_arb_pkg: opcode constants, FSM state encoding and reserved-opcode result shared by the arbiter slice.
package alu_arb_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [15:0] ALU_BAD_RESULT = 16'hFF38;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester, ALU and response signals of the shared-ALU arbiter.
interface alu_share_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int OP_W   = 3
);
    localparam int ID_W = $clog2(N_REQ);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*OP_W-1:0]   req_op;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic                    alu_start;
    logic [OP_W-1:0]         alu_op;
    logic [DATA_W-1:0]       alu_a;
    logic [DATA_W-1:0]       alu_b;
    logic [DATA_W-1:0]       alu_result;
    logic                    alu_zero;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_result;
    logic                    rsp_zero;
    logic                    busy;
    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_zero, busy
    );
    modport master (
        output req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_zero, busy
    );
endinterface

// File: rtl/alu_share_arbiter_rr_picker.sv
// rr_picker: request vector -> one-hot grant and index; round-robin after i_last,
// or lowest-index fixed priority when ALU_ARB_FIXED_PRIO_EN is defined.
module rr_picker #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic [ID_W-1:0]  i_last,
`endif
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx
);
`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        o_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (i_req[i]) o_idx = ID_W'(i);
    end
`else
    logic w_hit;
    always_comb begin
        o_idx = '0;
        w_hit = 1'b0;
        for (int k = 1; k <= N_REQ; k++)
            if (!w_hit && i_req[(int'(i_last) + k) % N_REQ]) begin
                o_idx = ID_W'((int'(i_last) + k) % N_REQ);
                w_hit = 1'b1;
            end
    end
`endif
    assign o_grant = (|i_req) ? (N_REQ'(1) << o_idx) : '0;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one fixed-latency ALU among N_REQ requesters, one transaction at a time.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 16,
    parameter int OP_W    = 3,
    parameter int ALU_LAT = 2
) (
    input logic clk,
    input logic reset,
    alu_share_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(ALU_LAT + 1);
    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_a, r_b, r_res;
    logic              r_zero;
    logic [ID_W-1:0]   r_id;
    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_idx;
    logic              w_accept;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]   r_last;
`endif
    rr_picker #(.N_REQ(N_REQ)) u_pick (
        .i_req  (bus.req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
        .i_last (r_last),
`endif
        .o_grant(w_grant),
        .o_idx  (w_idx)
    );
    // Gated by reset so no request is ever acknowledged while the block is being cleared.
    assign w_accept      = (r_state == S_IDLE) && (|bus.req_valid) && !reset;
    assign bus.req_ready = w_accept ? w_grant : '0;
    assign bus.alu_start = (r_state == S_ISSUE);
    assign bus.alu_op    = r_op;
    assign bus.alu_a     = r_a;
    assign bus.alu_b     = r_b;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_result = r_res;
    assign bus.rsp_zero  = r_zero;
    assign bus.busy      = (r_state != S_IDLE);
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = (r_cnt == '0) ? S_RESP : S_WAIT;
            S_RESP:  w_next = bus.rsp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_id    <= '0;
            r_res   <= '0;
            r_zero  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last  <= ID_W'(N_REQ - 1);
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op <= bus.req_op[w_idx*OP_W +: OP_W];
                r_a  <= bus.req_a[w_idx*DATA_W +: DATA_W];
                r_b  <= bus.req_b[w_idx*DATA_W +: DATA_W];
                r_id <= w_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
                r_last <= w_idx;
`endif
            end
            if (r_state == S_ISSUE)
                r_cnt <= CNT_W'(ALU_LAT - 1);
            else if (r_state == S_WAIT && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            if (r_state == S_WAIT && r_cnt == '0) begin
                r_res  <= bus.alu_result;
                r_zero <= bus.alu_zero;
            end
        end
    end
endmodule
